// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-outstanding-request memory handshake feeding an
// output slot plus a one-entry skid buffer, with redirect flush and discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    entry_t      slot_q, slot_d;
    entry_t      skid_q, skid_d;
    logic        slot_valid_q, slot_valid_d;

    logic        xfer;
    logic        consume;
    entry_t      fetched;

    // DISCARD keeps presenting the abandoned address until its response lands.
    assign imem_req  = (state_q != HOLD);
    assign imem_addr = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;

    assign xfer    = imem_req & imem_ack;
    assign consume = slot_valid_q & ~stall;
    assign fetched = '{instr: imem_rdata, pc: fetch_pc_q, pc4: fetch_pc_q + 32'd4};

    // An empty slot is held at zero so the bubble outputs need no extra muxing.
    assign instr_out    = slot_q.instr;
    assign PC_out       = slot_q.pc;
    assign PC_plus4_out = slot_q.pc4;
    assign valid_out    = slot_valid_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        disc_addr_d  = disc_addr_q;
        slot_d       = slot_q;
        skid_d       = skid_q;
        slot_valid_d = slot_valid_q;

        if (redirect) begin
            slot_d       = '0;
            skid_d       = '0;
            slot_valid_d = 1'b0;
            fetch_pc_d   = redirect_pc;
            case (state_q)
                FETCH: begin
                    state_d     = xfer ? FETCH : DISCARD;
                    disc_addr_d = fetch_pc_q;
                end
                HOLD:    state_d = FETCH;
                // A response arriving now is the one being discarded.
                DISCARD: state_d = xfer ? FETCH : DISCARD;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (xfer) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (!slot_valid_q || consume) begin
                            slot_d       = fetched;
                            slot_valid_d = 1'b1;
                        end else begin
                            skid_d  = fetched;
                            state_d = HOLD;
                        end
                    end else if (consume) begin
                        slot_d       = '0;
                        slot_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        slot_d       = skid_q;
                        skid_d       = '0;
                        slot_valid_d = 1'b1;
                        state_d      = FETCH;
                    end
                end
                DISCARD: begin
                    if (xfer) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: the data registers are reset as well because the outputs are
    // architecturally required to read zero while the slot is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            disc_addr_q  <= RESET_PC;
            slot_q       <= '0;
            skid_q       <= '0;
            slot_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            disc_addr_q  <= disc_addr_d;
            slot_q       <= slot_d;
            skid_q       <= skid_d;
            slot_valid_q <= slot_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-configurable
// instruction memory model whose data word is derived from the address.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4_out;
    logic        valid_out;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 0;
    int wait_cnt = 0;

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .PC_out       (PC_out),
        .PC_plus4_out (PC_plus4_out),
        .valid_out    (valid_out)
    );

    always #5 clock = ~clock;

    // Memory acks once a request has been held for mem_lat cycles.
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_addr ^ K;

    always @(posedge clock) begin
        if (reset || !imem_req || imem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset with ack present: nothing may be captured.
        step();
        step();
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_pc", PC_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc4", PC_plus4_out, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd1);
        check("rst_addr", imem_addr, 32'd0);

        // Zero-wait streaming: PC 0,4,8,...
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stream_valid", {31'd0, valid_out}, 32'd1);
            check("stream_pc", PC_out, 32'(4 * k));
            check("stream_pc4", PC_plus4_out, 32'(4 * k + 4));
            check("stream_instr", instr_out, 32'(4 * k) ^ K);
        end

        // Stall at 0x10: 0x14 goes to skid, request drops, outputs frozen.
        stall = 1'b1;
        step();
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_pc", PC_out, 32'h10);
        for (int k = 0; k < 4; k++) begin
            step();
            check("hold_frozen_pc", PC_out, 32'h10);
            check("hold_frozen_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        check("skid_pc", PC_out, 32'h14);
        check("skid_instr", instr_out, 32'h14 ^ K);
        check("resume_addr", imem_addr, 32'h18);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        step();
        check("resume_pc", PC_out, 32'h18);

        // Redirect to the top of the address space coinciding with a transfer.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap_flush_valid", {31'd0, valid_out}, 32'd0);
        check("wrap_flush_pc", PC_out, 32'd0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check("wrap_pc", PC_out, 32'hFFFF_FFFC);
        check("wrap_pc4", PC_plus4_out, 32'd0);
        check("wrap_next_addr", imem_addr, 32'd0);
        step();
        check("wrap_next_pc", PC_out, 32'd0);

        // Redirect + ack + stall on one edge: flush, no DISCARD.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        check("rsa_valid", {31'd0, valid_out}, 32'd0);
        check("rsa_instr", instr_out, 32'd0);
        check("rsa_pc", PC_out, 32'd0);
        check("rsa_addr", imem_addr, 32'h200);
        check("rsa_req", {31'd0, imem_req}, 32'd1);
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        check("rsa_pc_out", PC_out, 32'h200);
        check("rsa_valid_out", {31'd0, valid_out}, 32'd1);

        // Slow memory: bubble, then redirect while 0x204 is pending.
        mem_lat = 3;
        step();
        check("bubble_valid", {31'd0, valid_out}, 32'd0);
        check("bubble_pc", PC_out, 32'd0);
        check("bubble_addr", imem_addr, 32'h204);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        check("disc_addr", imem_addr, 32'h204);
        check("disc_valid", {31'd0, valid_out}, 32'd0);
        redirect = 1'b0;
        for (int k = 0; k < 10 && imem_addr !== 32'h100; k++) begin
            step();
            check("disc_drop_valid", {31'd0, valid_out}, 32'd0);
        end
        check("disc_new_addr", imem_addr, 32'h100);
        for (int k = 0; k < 10 && valid_out !== 1'b1; k++) step();
        check("disc_arrive_valid", {31'd0, valid_out}, 32'd1);
        check("disc_arrive_pc", PC_out, 32'h100);
        check("disc_arrive_instr", instr_out, 32'h100 ^ K);

        // Reset (with redirect) while in HOLD under stall.
        mem_lat = 0;
        stall   = 1'b1;
        step();
        check("hold2_req", {31'd0, imem_req}, 32'd0);
        check("hold2_pc", PC_out, 32'h100);
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        check("hrst_valid", {31'd0, valid_out}, 32'd0);
        check("hrst_pc", PC_out, 32'd0);
        check("hrst_instr", instr_out, 32'd0);
        check("hrst_req", {31'd0, imem_req}, 32'd1);
        check("hrst_addr", imem_addr, 32'd0);
        reset    = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        check("post_rst_pc", PC_out, 32'd0);
        check("post_rst_valid", {31'd0, valid_out}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  decode-stage hold; when 1, the output slot SHALL NOT be consumed this edge.
REQ-005 redirect  input  1  taken branch/jump; flush and restart fetch.
REQ-006 redirect_pc  input  32  restart address, sampled when redirect=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address, byte address.
REQ-009 imem_ack  input  1  memory response valid; meaningful only while imem_req=1.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 instr_out  output  32  fetched instruction to the decode register.
REQ-012 PC_out  output  32  address of instr_out.
REQ-013 PC_plus4_out  output  32  PC_out+4.
REQ-014 valid_out  output  1  1 = output slot holds a real instruction; 0 = bubble, outputs all zero.

Function
REQ-015 Memory handshake: transfer occurs on a rising edge with imem_req=1 and imem_ack=1; zero-wait ack (same cycle as first req) SHALL be supported; at most one request outstanding.
REQ-016 Once imem_req rises, imem_req and imem_addr SHALL stay constant until the transfer edge.
REQ-017 Storage: one output slot (drives *_out) plus one skid entry; consume = rising edge with valid_out=1 and stall=0.
REQ-018 States: FETCH (imem_req=1, imem_addr=fetch_pc), HOLD (imem_req=0, skid full), DISCARD (imem_req=1, imem_addr=old request address, response to be dropped).
REQ-019 FETCH, transfer, slot empty or consumed same edge: slot <= {imem_rdata, fetch_pc, fetch_pc+4}, valid_out<=1, fetch_pc<=fetch_pc+4, stay FETCH.
REQ-020 FETCH, transfer, slot full and not consumed: skid <= {imem_rdata, fetch_pc, fetch_pc+4}, fetch_pc+=4, go HOLD.
REQ-021 HOLD, consume edge: slot <= skid, skid empty, go FETCH; no consume: remain HOLD, all outputs unchanged.
REQ-022 FETCH without transfer, slot consumed: valid_out<=0, outputs <= 0 (bubble).
REQ-023 Redirect has priority over stall, ack and consume: slot and skid cleared, valid_out<=0, *_out<=0, fetch_pc<=redirect_pc, next edge.
REQ-024 Redirect while in FETCH with no transfer this edge: go DISCARD, keep old imem_addr; in DISCARD the next transfer is dropped and state goes FETCH at fetch_pc.
REQ-025 Redirect on the same edge as a transfer: data dropped, go FETCH with fetch_pc=redirect_pc (no DISCARD).
REQ-026 Redirect in HOLD: go FETCH; redirect in DISCARD: update fetch_pc only, stay DISCARD.
REQ-027 All PC arithmetic modulo 2^32; fetch_pc=32'hFFFF_FFFC yields PC_plus4_out=32'h0000_0000 and next fetch 0.
REQ-028 Instructions SHALL leave in program order, none duplicated or lost except those flushed by redirect.
REQ-029 Redirect_pc alignment is not checked; value used as given.

Reset
REQ-030 Reset edge: state FETCH, fetch_pc=RESET_PC, slot and skid empty, valid_out=0, instr_out=PC_out=PC_plus4_out=0.
REQ-031 First cycle after reset: imem_req=1, imem_addr=RESET_PC.
REQ-032 Reset mid-request: outstanding request abandoned; ack present on the reset edge ignored.
REQ-033 Reset overrides redirect, stall and ack.

Verification
REQ-034 Zero-wait memory, stall=0, RESET_PC=0: valid_out=1 from 1st edge after reset; PC_out sequence 0,4,8,... each cycle, PC_plus4_out=PC_out+4.
REQ-035 Slot full at PC 0x10, stall=1 held 5 cycles: ack for 0x14 enters skid, imem_req=0 (HOLD), outputs frozen at 0x10; stall release -> 0x10 then 0x14 on consecutive edges, fetch resumes at 0x18.
REQ-036 3-cycle-latency memory, request at 0x20 pending, redirect to 0x100: next cycle valid_out=0, imem_addr stays 0x20 until ack; that data dropped; next request 0x100, PC_out=0x100 reaches output.
REQ-037 Redirect to 0x200 on same edge as ack and stall=1: ack data and slot flushed, valid_out=0, next imem_addr=0x200, no DISCARD.
REQ-038 fetch_pc=0xFFFF_FFFC: PC_out=0xFFFF_FFFC, PC_plus4_out=0, next fetch address 0.
REQ-039 Reset asserted in HOLD with stall=1: next cycle valid_out=0, outputs 0, imem_req=1, imem_addr=RESET_PC.
